// File: rtl/core_pkg.sv
// Shared definitions for the LEGv8 forwarding / hazard logic.
//   XZR_IDX     : hardwired-zero register index
//   REG_ADDR_W  : architectural register address width
//   fwd_entry_t : one in-flight destination record of the shadow pipeline
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XZR_IDX    = 31;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] wr_reg;
        logic                  is_load;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port match against the shadow pipeline.
//   entries     : in : in-flight entries, index 0 = youngest (EX)
//   rd_en       : in : operand is actually used
//   rd_addr     : in : operand source register
//   match       : out: some stage will produce this operand
//   sel         : out: index of the youngest matching stage (0 when no match)
//   load_hazard : out: youngest match is a load whose data is not ready yet
module fwd_port_match
    import core_pkg::*;
#(
    parameter int NUM_FWD_STAGES   = 2,
    parameter int LOAD_READY_STAGE = 1,
    parameter int SEL_W            = 1,
    parameter int ZERO_REG         = XZR_IDX
) (
    input  fwd_entry_t [NUM_FWD_STAGES-1:0] entries,
    input  logic                            rd_en,
    input  logic [REG_ADDR_W-1:0]           rd_addr,
    output logic                            match,
    output logic [SEL_W-1:0]                sel,
    output logic                            load_hazard
);

    logic addr_ok;
    assign addr_ok = rd_en && (rd_addr != REG_ADDR_W'(ZERO_REG));

    // Walk oldest to youngest so the youngest hit is the last one written;
    // an older match can therefore never mask a younger load's hazard.
    always_comb begin
        match       = 1'b0;
        sel         = '0;
        load_hazard = 1'b0;
        for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
            if (addr_ok && entries[i].valid && entries[i].wr_en &&
                entries[i].wr_reg == rd_addr) begin
                match       = 1'b1;
                sel         = SEL_W'(i);
                load_hazard = (i < LOAD_READY_STAGE) && entries[i].is_load;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the pipelined LEGv8 core.
// Tracks NUM_FWD_STAGES in-flight destinations in a shadow shift register
// and produces, combinationally from those entries and the decode operands:
//   fwd_en / fwd_sel : per-port forward enable and source stage index
//   stall            : hold PC + IF/ID and inject a bubble into EX
//   stall_count      : saturating count of stalled cycles
// Inputs: clk, rst_n (async low), id_* decode instruction info, rd_en /
// rd_addr (packed per port), flush (kills decode and stage-0 instruction).
module fwd_hazard_unit #(
    parameter int NUM_READ_PORTS   = 2,
    parameter int REG_ADDR_W       = 5,
    parameter int NUM_FWD_STAGES   = 2,
    parameter int LOAD_READY_STAGE = 1,
    parameter int ZERO_REG         = 31,
    parameter int STALL_CNT_W      = 16,
    localparam int SEL_W = (NUM_FWD_STAGES > 1) ? $clog2(NUM_FWD_STAGES) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               id_valid,
    input  logic                               id_wr_en,
    input  logic [REG_ADDR_W-1:0]              id_wr_reg,
    input  logic                               id_is_load,
    input  logic [NUM_READ_PORTS-1:0]          rd_en,
    input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rd_addr,
    input  logic                               flush,
    output logic [NUM_READ_PORTS-1:0]          fwd_en,
    output logic [NUM_READ_PORTS*SEL_W-1:0]    fwd_sel,
    output logic                               stall,
    output logic [STALL_CNT_W-1:0]             stall_count
);

    import core_pkg::*;

    // Entry records are sized by the shared register width.
    if (REG_ADDR_W != core_pkg::REG_ADDR_W) begin : g_bad_addr_w
        $error("fwd_hazard_unit: REG_ADDR_W must equal core_pkg::REG_ADDR_W");
    end

    fwd_entry_t [NUM_FWD_STAGES-1:0] stage_q, stage_d;
    logic [STALL_CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

    logic [NUM_READ_PORTS-1:0]             hazard;
    logic [NUM_READ_PORTS-1:0][SEL_W-1:0]  sel_arr;

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
        fwd_port_match #(
            .NUM_FWD_STAGES   (NUM_FWD_STAGES),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SEL_W            (SEL_W),
            .ZERO_REG         (ZERO_REG)
        ) u_match (
            .entries     (stage_q),
            .rd_en       (rd_en[p]),
            .rd_addr     (rd_addr[p*REG_ADDR_W +: REG_ADDR_W]),
            .match       (fwd_en[p]),
            .sel         (sel_arr[p]),
            .load_hazard (hazard[p])
        );
    end

    assign fwd_sel     = sel_arr;
    // A taken branch kills the decode instruction, so it cannot stall.
    assign stall       = id_valid & ~flush & (|hazard);
    assign stall_count = stall_cnt_q;

    always_comb begin
        stage_d            = stage_q;
        stage_d[0].valid   = id_valid & ~stall & ~flush;
        stage_d[0].wr_en   = id_wr_en;
        stage_d[0].wr_reg  = id_wr_reg;
        stage_d[0].is_load = id_is_load;
        // Older stages always drain; flush kills the instruction leaving EX.
        for (int i = 1; i < NUM_FWD_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
            if (i == 1 && flush) stage_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_wr_en, id_is_load, flush;
    logic [4:0]  id_wr_reg;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  fwd_en, fwd_sel;
    logic        stall;
    logic [15:0] stall_count;

    // Second instance: single tracked stage, narrow counter for saturation.
    logic        rst_b_n;
    logic        id_valid_b, id_wr_en_b, id_is_load_b, flush_b;
    logic [4:0]  id_wr_reg_b;
    logic [1:0]  rd_en_b;
    logic [9:0]  rd_addr_b;
    logic [1:0]  fwd_en_b, fwd_sel_b;
    logic        stall_b;
    logic [3:0]  stall_count_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        int          step;
        logic [1:0]  fen;
        logic [1:0]  fsel;
        logic        st;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .rd_en(rd_en),
        .rd_addr(rd_addr), .flush(flush), .fwd_en(fwd_en), .fwd_sel(fwd_sel),
        .stall(stall), .stall_count(stall_count)
    );

    fwd_hazard_unit #(.NUM_FWD_STAGES(1), .STALL_CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .id_valid(id_valid_b), .id_wr_en(id_wr_en_b),
        .id_wr_reg(id_wr_reg_b), .id_is_load(id_is_load_b), .rd_en(rd_en_b),
        .rd_addr(rd_addr_b), .flush(flush_b), .fwd_en(fwd_en_b), .fwd_sel(fwd_sel_b),
        .stall(stall_b), .stall_count(stall_count_b)
    );

    task automatic check_a();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL scoreboard_empty got 0 entries need 1");
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        assert (fwd_en === e.fen) else begin
            n_err++; $error("FAIL step%0d fwd_en got %b exp %b", e.step, fwd_en, e.fen);
        end
        n_cmp++;
        assert (fwd_sel === e.fsel) else begin
            n_err++; $error("FAIL step%0d fwd_sel got %b exp %b", e.step, fwd_sel, e.fsel);
        end
        n_cmp++;
        assert (stall === e.st) else begin
            n_err++; $error("FAIL step%0d stall got %b exp %b", e.step, stall, e.st);
        end
        n_cmp++;
        assert (stall_count === e.cnt) else begin
            n_err++; $error("FAIL step%0d stall_count got %0d exp %0d", e.step, stall_count, e.cnt);
        end
    endtask

    // One decode cycle: drive after the edge, queue the expectation, check
    // at the falling edge.
    task automatic step(input int n, input logic v, input logic we, input logic [4:0] wr,
                        input logic ld, input logic [1:0] re, input logic [4:0] a0,
                        input logic [4:0] a1, input logic fl, input logic [1:0] efen,
                        input logic [1:0] efsel, input logic est, input logic [15:0] ecnt);
        @(posedge clk); #1;
        id_valid = v; id_wr_en = we; id_wr_reg = wr; id_is_load = ld;
        rd_en = re; rd_addr = {a1, a0}; flush = fl;
        sb.push_back('{step: n, fen: efen, fsel: efsel, st: est, cnt: ecnt});
        @(negedge clk);
        check_a();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic       exp_st;
        logic [3:0] exp_cnt_b;

        rst_n = 1'b0; rst_b_n = 1'b0;
        id_valid = 0; id_wr_en = 0; id_wr_reg = 0; id_is_load = 0;
        rd_en = 0; rd_addr = 0; flush = 0;
        id_valid_b = 1; id_wr_en_b = 1; id_wr_reg_b = 5'd5; id_is_load_b = 1;
        rd_en_b = 2'b01; rd_addr_b = {5'd0, 5'd5}; flush_b = 0;

        @(negedge clk);
        sb.push_back('{step: 0, fen: 2'b00, fsel: 2'b00, st: 1'b0, cnt: 16'd0});
        check_a();
        @(posedge clk); #1 rst_n = 1'b1;

        //   n  v  we wr  ld re     a0  a1  fl  fen    fsel   st  cnt
        step(1, 1, 1, 1,  0, 2'b00, 0,  0,  0, 2'b00, 2'b00, 0, 0);   // ADD X1
        step(2, 1, 1, 4,  0, 2'b01, 1,  0,  0, 2'b01, 2'b00, 0, 0);   // X1 from EX
        step(3, 1, 1, 9,  0, 2'b01, 1,  0,  0, 2'b01, 2'b01, 0, 0);   // X1 from MEM
        step(4, 1, 1, 2,  0, 2'b00, 0,  0,  0, 2'b00, 2'b00, 0, 0);   // X2
        step(5, 1, 1, 2,  0, 2'b00, 0,  0,  0, 2'b00, 2'b00, 0, 0);   // X2 again
        step(6, 1, 0, 0,  0, 2'b10, 0,  2,  0, 2'b10, 2'b00, 0, 0);   // youngest wins
        step(7, 1, 1, 3,  1, 2'b00, 0,  0,  0, 2'b00, 2'b00, 0, 0);   // LDUR X3
        step(8, 1, 1, 10, 0, 2'b01, 3,  0,  0, 2'b01, 2'b00, 1, 0);   // load-use
        step(9, 1, 1, 10, 0, 2'b11, 3,  10, 0, 2'b01, 2'b01, 0, 1);   // bubble in EX
        step(10, 1, 0, 0, 0, 2'b10, 0,  10, 0, 2'b10, 2'b00, 0, 1);
        step(11, 1, 1, 31, 1, 2'b00, 0, 0,  0, 2'b00, 2'b00, 0, 1);   // XZR writers
        step(12, 1, 1, 31, 1, 2'b00, 0, 0,  0, 2'b00, 2'b00, 0, 1);
        step(13, 1, 0, 0, 0, 2'b11, 31, 31, 0, 2'b00, 2'b00, 0, 1);
        step(14, 1, 1, 5, 1, 2'b00, 0,  0,  0, 2'b00, 2'b00, 0, 1);   // LDUR X5
        step(15, 1, 1, 11, 0, 2'b01, 5, 0,  1, 2'b01, 2'b00, 0, 1);   // flush wins
        step(16, 1, 0, 0, 0, 2'b11, 5,  11, 0, 2'b00, 2'b00, 0, 1);   // both killed
        step(17, 1, 1, 12, 1, 2'b00, 0, 0,  0, 2'b00, 2'b00, 0, 1);   // LDUR X12
        step(18, 1, 1, 13, 0, 2'b01, 12, 0, 0, 2'b01, 2'b00, 1, 1);   // stalling

        // Asynchronous reset in the middle of the stalled cycle.
        #2 rst_n = 1'b0;
        #1;
        sb.push_back('{step: 19, fen: 2'b00, fsel: 2'b00, st: 1'b0, cnt: 16'd0});
        check_a();
        @(posedge clk); #1 rst_n = 1'b1;
        id_valid = 0;

        // Single-stage instance: a self-dependent load alternates capture and
        // stall, driving the 4-bit counter into saturation.
        @(posedge clk); #1 rst_b_n = 1'b1;
        exp_cnt_b = 4'd0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            exp_st = j[0];
            n_cmp++;
            assert (stall_b === exp_st) else begin
                n_err++; $error("FAIL b%0d stall got %b exp %b", j, stall_b, exp_st);
            end
            n_cmp++;
            assert (fwd_en_b === {1'b0, exp_st}) else begin
                n_err++; $error("FAIL b%0d fwd_en got %b exp %b", j, fwd_en_b, {1'b0, exp_st});
            end
            n_cmp++;
            assert (fwd_sel_b === 2'b00) else begin
                n_err++; $error("FAIL b%0d fwd_sel got %b exp 00", j, fwd_sel_b);
            end
            n_cmp++;
            assert (stall_count_b === exp_cnt_b) else begin
                n_err++; $error("FAIL b%0d stall_count got %0d exp %0d", j, stall_count_b, exp_cnt_b);
            end
            if (exp_st && exp_cnt_b != 4'hF) exp_cnt_b = exp_cnt_b + 4'd1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined LEGv8 core. Successor to the fixed two-stage EX/MEM forwarding selector.
- Keeps its own registered shadow pipeline of in-flight destination registers, NUM_FWD_STAGES deep.
- Drives per-read-port forwarding enables and stage selects for NUM_READ_PORTS operands.
- Detects load-use hazards and asserts a decode stall. Supports flush and keeps a saturating stall counter.

Parameters:
- NUM_READ_PORTS, 2: number of operand read ports checked (port 0 = Rn, port 1 = Rm/Rd after reg2loc mux).
- REG_ADDR_W, 5: register address width.
- NUM_FWD_STAGES, 2: tracked in-flight stages. Stage 0 = EX, stage 1 = MEM, and so on.
- LOAD_READY_STAGE, 1: first stage index at which a load's result can be forwarded.
- ZERO_REG, 31: hardwired-zero register index (XZR). It is never forwarded and never stalls.
- STALL_CNT_W, 16: width of the stall performance counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- id_valid, input, 1: decode-stage instruction is valid.
- id_wr_en, input, 1: decode instruction writes a register.
- id_wr_reg, input, REG_ADDR_W: decode destination register.
- id_is_load, input, 1: decode instruction is a load (LDUR).
- rd_en, input, NUM_READ_PORTS: per-port operand-used flag.
- rd_addr, input, NUM_READ_PORTS*REG_ADDR_W: packed per-port source addresses. Port p occupies bits [p*REG_ADDR_W +: REG_ADDR_W].
- flush, input, 1: kill the decode instruction and the instruction in stage 0 (branch taken).
- fwd_en, output, NUM_READ_PORTS: per-port forward-enable.
- fwd_sel, output, NUM_READ_PORTS*SEL_W: per-port source stage index, where SEL_W = max(1, $clog2(NUM_FWD_STAGES)).
- stall, output, 1: hold PC and IF/ID, and inject a bubble into EX.
- stall_count, output, STALL_CNT_W: number of stall cycles, saturating.

Behaviour:
- Each stage entry holds {valid, wr_en, wr_reg, is_load}.
- Reset (async, rst_n=0):
  - All entry valid bits = 0.
  - stall_count = 0.
  - Outputs then evaluate to fwd_en=0, fwd_sel=0, stall=0.
- Per-port match, combinational from the registered entries:
  - Stage i matches port p when entry i is valid, wr_en=1, wr_reg==rd_addr[p], rd_addr[p]!=ZERO_REG, and rd_en[p]=1.
- Priority: the youngest (lowest-index) matching stage wins.
  - fwd_en[p] = 1 when any stage matches.
  - fwd_sel[p] = index of the youngest matching stage.
  - fwd_sel[p] = 0 when fwd_en[p] = 0.
- Load-use hazard for port p: the youngest matching stage has i < LOAD_READY_STAGE and is_load=1.
  - An older match never overrides a hazard raised by a younger load.
- stall = id_valid & !flush & (OR over ports of the load-use hazard).
- Forwarding outputs are valid in the same cycle as the decode inputs. They are combinational, with zero cycles of latency.
- Shift on each rising edge:
  - stage[i] <= stage[i-1] for i >= 1. This happens unconditionally, because older stages always drain.
  - stage[0] <= {id_valid & !stall & !flush, id_wr_en, id_wr_reg, id_is_load}.
  - A stall therefore inserts exactly one bubble per stalled cycle.
- Flush:
  - The stage-0 entry is forced invalid as it shifts into stage 1, i.e. stage[1].valid <= 0.
  - The decode instruction is not captured.
  - flush overrides stall in the same cycle.
- stall_count increments by 1 on each edge where stall=1 and saturates at all-ones.
- Reset asserted mid-stall clears all entries immediately. stall falls in the same cycle, with no glitch requirements beyond settling within the cycle.
- A writer with id_wr_en=0 or wr_reg==ZERO_REG is tracked but never matches.
- NUM_FWD_STAGES=1 is legal, with SEL_W=1 and fwd_sel always 0.

Decomposition:
- Shared package core_pkg:
  - typedef fwd_entry_t {valid, wr_en, wr_reg, is_load}.
  - Constant XZR_IDX = 31.
  - Constant REG_ADDR_W = 5.
- One natural sub-module, fwd_port_match: one instance per read port. It takes the entry array and one address, and produces match, sel and load_hazard via a youngest-first priority encoder.
- The top level holds the shift register, the stall OR-reduce, and the counter.

Test Plan:
- ADD X1 issued, next cycle SUB reads X1 on port 0 -> fwd_en[0]=1, fwd_sel[0]=0, stall=0. One cycle later, with an unrelated instruction in between, a reader of X1 sees fwd_sel=1.
- X2 written in both stage 0 and stage 1, port 1 reads X2 -> fwd_sel[1]=0, the youngest stage.
- LDUR X3, next instruction reads X3 -> stall=1 for exactly 1 cycle, stall_count 0->1. On the following cycle fwd_en=1, fwd_sel=1, stall=0, and stage 0 holds a bubble.
- Reader of X31 with X31 in flight in every stage -> fwd_en=0, stall=0.
- flush=1 while a load-use hazard is present -> stall=0. The next cycle stage[1].valid=0 and stage[0].valid=0.
- Force 65535 stalls, then one more -> stall_count holds at 16'hFFFF. Drop rst_n mid-stall -> stall=0 and stall_count=0 immediately.
